shifter_pipe: RTL and testbench
===============================

// Module: shifter_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter for the CPU execute path and DSP-style helpers.
//  Performs rotate/shift left/right by 0..WIDTH-1 using log2(WIDTH) mux levels.
//  Optional register boundaries sit between the levels. A valid/ready handshake lets the
//  block stall under downstream backpressure without losing or reordering operations.
// PARAMETERS
//  WIDTH   16  data width; power of two, >= 4; CNT_W = $clog2(WIDTH) is derived
//  PIPE    1   1: register after every mux level (latency CNT_W); 0: one output register (latency 1)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block accepts a beat this cycle (in_valid & in_ready = accept)
//  in_data    in   WIDTH  operand
//  in_cnt     in   CNT_W  shift amount 0..WIDTH-1
//  in_op      in   2      00 rol, 01 sll, 10 ror, 11 srl (op[1]=right, op[0]=logical/zero-fill)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result (out_valid & out_ready = retire)
//  out_data   out  WIDTH  result
//  out_zero   out  1      [SHIFTER_FLAGS_EN] out_data == 0
//  out_carry  out  1      [SHIFTER_FLAGS_EN] last bit shifted/rotated out
// BEHAVIOUR
//  - Reset (async, immediate): all stage valid bits 0, all stage data/cnt/op regs 0.
//    Outputs are out_valid=0, out_data=0, out_zero=0, out_carry=0. in_ready=1 once rst deasserts.
//  - Level k (k=0..CNT_W-1) shifts by 2^k when cnt[k]=1, else passes through.
//    Rotates wrap the bits; logical shifts zero-fill vacated positions.
//  - Stage registers carry {valid, data, remaining cnt, op} with the data.
//  - Latency: PIPE=1 -> result appears CNT_W cycles after accept; PIPE=0 -> 1 cycle.
//  - Stall rule: stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
//  - On stall, every stage holds, including bubbles; bubbles are not compressed.
//  - Throughput: one beat per cycle when out_ready=1. An accept and a retire in the same
//    cycle are both legal.
//  - With in_valid=0 and no stall, a bubble (valid=0) enters stage 0.
//    The data path of an invalid stage is don't-care, but out_data only changes on advance.
//  - out_data/out_valid/flags stay stable while stalled; order is strictly FIFO.
//  - cnt=0: out_data = in_data for all ops.
//  - rst asserted mid-operation: all in-flight beats are dropped, with no partial output.
// CONFIGURATION
//  - SHIFTER_FLAGS_EN defined:
//    - out_zero and out_carry are present and pipelined alongside data.
//    - out_carry = 0 if cnt==0. Otherwise in_data[WIDTH-cnt] for left ops and
//      in_data[cnt-1] for right ops (same rule for rotates and shifts).
//    - Carry is computed in stage 0 and travels with the beat; out_zero is computed on the
//      final stage data.
//  - Not defined: out_zero/out_carry ports are absent; no flag registers.
// TESTING (WIDTH=16, PIPE=1 unless stated)
//  - Reset: rst=1 -> out_valid=0, out_data=16'h0000, out_zero=0, out_carry=0.
//    After release, in_ready=1.
//  - rol 16'h8001 cnt=1 -> out_data=16'h0003 exactly 4 cycles after accept, carry=1.
//  - ror 16'h8001 cnt=4 -> 16'h1800, carry=0.
//    srl 16'h8001 cnt=4 -> 16'h0800, carry=0.
//    sll 16'hFFFF cnt=15 -> 16'h8000, carry=1.
//    srl 16'h0001 cnt=1 -> 16'h0000, zero=1, carry=1.
//  - Backpressure: send 4 back-to-back beats with out_ready=0 for 3 cycles once the first
//    result is valid -> in_ready=0 during the stall and out_data held. All 4 results retire
//    in order with no loss or duplication.
//  - Reset mid-flight: assert rst with 3 beats in the pipe -> out_valid drops in the same
//    cycle, and none of the 3 results ever appears.
//  - WIDTH=32, PIPE=0: srl 32'h80000000 cnt=31 -> 32'h00000001 one cycle after accept.
//    sll 32'h00000001 cnt=0 -> 32'h00000001.

Source files
------------

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: rol/sll/ror/srl by 0..WIDTH-1 using log2(WIDTH) mux levels.
// Latency: CNT_W cycles with PIPE=1 (a register after every level), 1 cycle with PIPE=0.
// Backpressure: stall = out_valid & ~out_ready freezes every stage (bubbles included); in_ready = ~stall.
// Optional flags: define SHIFTER_FLAGS_EN to add out_zero / out_carry, pipelined with the data.
module shifter_pipe #(
    parameter int WIDTH = 16,
    parameter int PIPE  = 1,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef SHIFTER_FLAGS_EN
   ,output logic             out_zero,
    output logic             out_carry
`endif
);

    // Number of registered stages: one per mux level when pipelined, else a single output stage.
    localparam int NSTG = (PIPE != 0) ? CNT_W : 1;

    // Operation encoding: bit 1 selects right, bit 0 selects zero-fill (logical) over wrap.
    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;

    // One mux level: shift/rotate by a fixed amount when enabled, otherwise pass through.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic             en,
        input int               amt,
        input logic [1:0]       op
    );
        logic [WIDTH-1:0] res;
        case (op)
            OP_ROL:  res = (d << amt) | (d >> (WIDTH - amt));
            OP_SLL:  res = d << amt;
            OP_ROR:  res = (d >> amt) | (d << (WIDTH - amt));
            default: res = d >> amt;
        endcase
        return en ? res : d;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic stall;

    // Whole pipe freezes when the output holds an unretired result.
    always_comb begin
        stall    = out_valid & ~out_ready;
        in_ready = ~stall;
    end

    // ------------------------------------------------------------------
    // Mux levels. lvl_* are the inputs to level k, lvl_out its result.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] lvl_in  [CNT_W];
    logic [WIDTH-1:0] lvl_out [CNT_W];
    logic [CNT_W-1:0] lvl_cnt [CNT_W];
    logic [1:0]       lvl_op  [CNT_W];

    // Stage registers carrying the beat (valid + data); cnt/op live in the pipelined branch.
    logic             valid_q [NSTG];
    logic             valid_d [NSTG];
    logic [WIDTH-1:0] data_q  [NSTG];
    logic [WIDTH-1:0] data_d  [NSTG];

    assign lvl_in[0]  = in_data;
    assign lvl_cnt[0] = in_cnt;
    assign lvl_op[0]  = in_op;

    genvar k;
    generate
        for (k = 0; k < CNT_W; k++) begin : g_lvl
            assign lvl_out[k] = shift_level(lvl_in[k], lvl_cnt[k][k], 1 << k, lvl_op[k]);
        end

        if (PIPE != 0) begin : g_pipe
            // Remaining shift amount and op travel with the beat between levels.
            logic [CNT_W-1:0] cnt_q [CNT_W-1];
            logic [1:0]       op_q  [CNT_W-1];

            for (k = 1; k < CNT_W; k++) begin : g_link
                assign lvl_in[k]  = data_q[k-1];
                assign lvl_cnt[k] = cnt_q[k-1];
                assign lvl_op[k]  = op_q[k-1];
            end

            // Control side of the inter-level registers; advances with the data.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < CNT_W - 1; i++) begin
                        cnt_q[i] <= '0;
                        op_q[i]  <= '0;
                    end
                end else if (!stall) begin
                    for (int i = 0; i < CNT_W - 1; i++) begin
                        cnt_q[i] <= lvl_cnt[i];
                        op_q[i]  <= lvl_op[i];
                    end
                end
            end
        end else begin : g_flat
            // All levels chained combinationally; the operands come straight from the input.
            for (k = 1; k < CNT_W; k++) begin : g_link
                assign lvl_in[k]  = lvl_out[k-1];
                assign lvl_cnt[k] = in_cnt;
                assign lvl_op[k]  = in_op;
            end
        end
    endgenerate

    // Next-state of each stage: stage 0 takes the input (a bubble when in_valid=0), later stages shift down.
    always_comb begin
        for (int i = 0; i < NSTG; i++) begin
            data_d[i]  = (PIPE != 0) ? lvl_out[i] : lvl_out[CNT_W-1];
            valid_d[i] = 1'b0;
        end
        valid_d[0] = in_valid;
        for (int i = 1; i < NSTG; i++) begin
            valid_d[i] = valid_q[i-1];
        end
    end

    // Stage registers: cleared immediately on reset, hold everything while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSTG; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
        end else if (!stall) begin
            for (int i = 0; i < NSTG; i++) begin
                valid_q[i] <= valid_d[i];
                data_q[i]  <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q[NSTG-1];
    assign out_data  = data_q[NSTG-1];

`ifdef SHIFTER_FLAGS_EN
    // ------------------------------------------------------------------
    // Flags. Carry is the last bit pushed out of the word, taken from the
    // original operand at entry: bit WIDTH-cnt for left ops, bit cnt-1 for
    // right ops. WIDTH-cnt modulo WIDTH is simply -cnt in CNT_W bits.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] idx_l;
    logic [CNT_W-1:0] idx_r;
    logic             carry_in;
    logic             carry_q [NSTG];
    logic             carry_d [NSTG];
    logic             zero_q;

    // Stage-0 carry extraction from the incoming operand.
    always_comb begin
        idx_l    = '0 - in_cnt;
        idx_r    = in_cnt - CNT_W'(1);
        carry_in = 1'b0;
        if (in_cnt != '0) begin
            carry_in = in_op[1] ? in_data[idx_r] : in_data[idx_l];
        end
    end

    // Carry moves down the pipe alongside its beat.
    always_comb begin
        carry_d[0] = carry_in;
        for (int i = 1; i < NSTG; i++) begin
            carry_d[i] = carry_q[i-1];
        end
    end

    // Flag registers; zero is evaluated on the data entering the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSTG; i++) begin
                carry_q[i] <= 1'b0;
            end
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int i = 0; i < NSTG; i++) begin
                carry_q[i] <= carry_d[i];
            end
            zero_q <= (data_d[NSTG-1] == '0);
        end
    end

    assign out_zero  = zero_q;
    assign out_carry = carry_q[NSTG-1];
`endif

endmodule

// File: tb/tb_shifter_pipe.sv
module tb_shifter_pipe;

    localparam logic [1:0] ROL = 2'b00;
    localparam logic [1:0] SLL = 2'b01;
    localparam logic [1:0] ROR = 2'b10;
    localparam logic [1:0] SRL = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 16-bit pipelined instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data, out_data;
    logic [3:0]  in_cnt;
    logic [1:0]  in_op;
    logic        out_zero, out_carry;

    // 32-bit single-register instance
    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [31:0] w_in_data, w_out_data;
    logic [4:0]  w_in_cnt;
    logic [1:0]  w_in_op;
    logic        w_out_zero, w_out_carry;

    shifter_pipe #(.WIDTH(16), .PIPE(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SHIFTER_FLAGS_EN
       ,.out_zero  (out_zero),
        .out_carry (out_carry)
`endif
    );

    shifter_pipe #(.WIDTH(32), .PIPE(0)) u_dut_w (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_in_data),
        .in_cnt    (w_in_cnt),
        .in_op     (w_in_op),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_data  (w_out_data)
`ifdef SHIFTER_FLAGS_EN
       ,.out_zero  (w_out_zero),
        .out_carry (w_out_carry)
`endif
    );

`ifndef SHIFTER_FLAGS_EN
    assign out_zero    = 1'b0;
    assign out_carry   = 1'b0;
    assign w_out_zero  = 1'b0;
    assign w_out_carry = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic        z;
        logic        c;
    } exp_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] din;
        logic [3:0]  cnt;
        logic [15:0] dexp;
        logic        z;
        logic        c;
    } vec_t;

    exp_t sb_q[$];
    exp_t w_q[$];
    exp_t mon_e, w_mon_e;
    vec_t vt[16];

    int n_vec = 0;
    int n_err = 0;
    int n_ret = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s got=timeout expected=event", name);
    endtask

    // Scoreboard monitor, 16-bit instance: every retire pops one expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_ret++;
            if (sb_q.size() == 0) begin
                timeout("unexpected_result");
            end else begin
                mon_e = sb_q.pop_front();
                check("data16", {16'h0, out_data}, mon_e.d);
`ifdef SHIFTER_FLAGS_EN
                check("zero16", {31'h0, out_zero}, {31'h0, mon_e.z});
                check("carry16", {31'h0, out_carry}, {31'h0, mon_e.c});
`endif
            end
        end
    end

    // Scoreboard monitor, 32-bit instance.
    always @(negedge clk) begin
        if (!rst && w_out_valid && w_out_ready) begin
            if (w_q.size() == 0) begin
                timeout("unexpected_result32");
            end else begin
                w_mon_e = w_q.pop_front();
                check("data32", w_out_data, w_mon_e.d);
`ifdef SHIFTER_FLAGS_EN
                check("zero32", {31'h0, w_out_zero}, {31'h0, w_mon_e.z});
                check("carry32", {31'h0, w_out_carry}, {31'h0, w_mon_e.c});
`endif
            end
        end
    end

    // Present one beat to the 16-bit instance; the expectation is queued at the accepting edge.
    task automatic send(input vec_t v);
        int tries = 0;
        in_valid = 1'b1;
        in_data  = v.din;
        in_cnt   = v.cnt;
        in_op    = v.op;
        @(negedge clk);
        while (!in_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) timeout("accept16");
        else sb_q.push_back('{d: {16'h0, v.dexp}, z: v.z, c: v.c});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wsend(input logic [1:0] op, input logic [31:0] d, input logic [4:0] c,
                         input logic [31:0] e, input logic ez, input logic ec);
        int tries = 0;
        w_in_valid = 1'b1;
        w_in_data  = d;
        w_in_cnt   = c;
        w_in_op    = op;
        @(negedge clk);
        while (!w_in_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (!w_in_ready) timeout("accept32");
        else w_q.push_back('{d: e, z: ez, c: ec});
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((sb_q.size() != 0 || w_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0 || w_q.size() != 0) timeout(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ret0;
        int seen;

        //            op   din       cnt    expected  z     c
        vt[0]  = '{ROR, 16'h8001, 4'd4,  16'h1800, 1'b0, 1'b0};
        vt[1]  = '{SRL, 16'h8001, 4'd4,  16'h0800, 1'b0, 1'b0};
        vt[2]  = '{SLL, 16'hFFFF, 4'd15, 16'h8000, 1'b0, 1'b1};
        vt[3]  = '{SRL, 16'h0001, 4'd1,  16'h0000, 1'b1, 1'b1};
        vt[4]  = '{ROL, 16'h1234, 4'd8,  16'h3412, 1'b0, 1'b0};
        vt[5]  = '{ROR, 16'h000F, 4'd15, 16'h001E, 1'b0, 1'b0};
        vt[6]  = '{SLL, 16'h00F0, 4'd4,  16'h0F00, 1'b0, 1'b0};
        vt[7]  = '{SRL, 16'hABCD, 4'd8,  16'h00AB, 1'b0, 1'b1};
        vt[8]  = '{SLL, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0, 1'b0};
        vt[9]  = '{ROR, 16'h0000, 4'd0,  16'h0000, 1'b1, 1'b0};
        vt[10] = '{ROL, 16'h8001, 4'd15, 16'hC000, 1'b0, 1'b0};
        vt[11] = '{SLL, 16'h8001, 4'd1,  16'h0002, 1'b0, 1'b1};
        vt[12] = '{SRL, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b0};
        vt[13] = '{ROR, 16'h0001, 4'd1,  16'h8000, 1'b0, 1'b1};
        vt[14] = '{ROL, 16'h1234, 4'd0,  16'h1234, 1'b0, 1'b0};
        vt[15] = '{SRL, 16'hFFFF, 4'd0,  16'hFFFF, 1'b0, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_cnt = '0; in_op = '0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_data = '0; w_in_cnt = '0; w_in_op = '0; w_out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data", {16'h0, out_data}, 32'h0);
        check("rst_out_zero", {31'h0, out_zero}, 32'h0);
        check("rst_out_carry", {31'h0, out_carry}, 32'h0);
        check("rst_w_out_valid", {31'h0, w_out_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;

        // Latency: rol 8001 by 1 must appear in the 4th cycle after accept
        send('{ROL, 16'h8001, 4'd1, 16'h0003, 1'b0, 1'b1});
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check("latency16", lat, 4);
        drain("drain_latency");

        // Directed table, back to back
        foreach (vt[i]) send(vt[i]);
        drain("drain_table");

        // Backpressure: four beats, then hold the output for 3 cycles as the first result lands
        ret0 = n_ret;
        for (int i = 0; i < 4; i++) send(vt[i]);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'h0, in_ready}, 32'h0);
            check("bp_out_valid", {31'h0, out_valid}, 32'h1);
            check("bp_out_data_held", {16'h0, out_data}, 32'h1800);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("drain_bp");
        repeat (6) @(negedge clk);
        check("bp_retired", n_ret - ret0, 4);
        @(posedge clk);
        #1;

        // Reset with three beats in flight: nothing may come out afterwards
        out_ready = 1'b0;
        for (int i = 4; i < 7; i++) send(vt[i]);
        @(posedge clk);
        #1;
        check("mid_pre_valid", {31'h0, out_valid}, 32'h1);
        sb_q.delete();
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_out_data", {16'h0, out_data}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_no_output", seen, 0);
        @(posedge clk);
        #1;

        // 32-bit, single output register: result one cycle after accept
        wsend(SRL, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0);
        @(negedge clk);
        check("latency32", {31'h0, w_out_valid}, 32'h1);
        @(posedge clk);
        #1;
        wsend(SLL, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0);
        wsend(ROR, 32'h00000003, 5'd1, 32'h80000001, 1'b0, 1'b1);
        drain("drain_w");

        check("sb16_empty", sb_q.size(), 0);
        check("sb32_empty", w_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
